student_iis_sample_bridge: RTL and testbench
============================================

# student_iis_sample_bridge

Sample-rate bridge between the IIS codec handler and the FIR filter core. Converts the handler's held-level receive valid into single-sample events, buffers received samples in a FIFO toward the filter (valid/ready), and buffers filtered samples in a second FIFO toward the handler. Transmit samples are paced one per receive event, so the handler's DAC data stays stable for a full LRCLK half-period.

## Interface
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `UNDERRUN_ZERO`, 0: on TX underrun, 1 drives zero; 0 repeats the last sample.
- `clk_i` in 1: system clock, same domain as the IIS handler.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `iis_data_i` in 16: received mono sample from the IIS handler.
- `iis_valid_i` in 1: receive valid level from the IIS handler; held high for many cycles per sample.
- `iis_data_o` out 16: sample to the IIS handler, held between ticks.
- `iis_valid_o` out 1: one-cycle strobe to the IIS handler.
- `rx_data_o` out 16: sample to the filter.
- `rx_valid_o` out 1: RX FIFO not empty.
- `rx_ready_i` in 1: filter accepts `rx_data_o`.
- `tx_data_i` in 16: filtered sample.
- `tx_valid_i` in 1: `tx_data_i` valid.
- `tx_ready_o` out 1: TX FIFO not full.
- `clear_status_i` in 1: clears sticky flags and counters.
- `rx_overflow_o` out 1: sticky; an RX sample was dropped.
- `tx_underrun_o` out 1: sticky; a tick found the TX FIFO empty.

## Operation
- Tick: `iis_valid_i`=1 while the registered previous value is 0. The previous-value register resets to 0, so a level already high at reset release counts as a tick.
- RX path, on tick:
  - `iis_data_i` is pushed into the RX FIFO.
  - If the RX FIFO is full and no pop occurs in the same cycle, the sample is dropped and `rx_overflow_o` is set.
  - If full with a simultaneous pop, the push is accepted.
- RX pop: `rx_valid_o && rx_ready_i`. The FIFO is first-word-fall-through; `rx_data_o` shows the head entry.
- TX push: `tx_valid_i && tx_ready_o`. A simultaneous push and pop on a full FIFO is accepted only via pop; `tx_ready_o` stays low while full.
- TX pop, on tick:
  - If TX FIFO not empty: pop the head into the `iis_data_o` register.
  - If empty: load 0 (`UNDERRUN_ZERO`=1) or keep the current value (0), and set `tx_underrun_o`.
  - `iis_valid_o` pulses in both cases.
- Empty FIFO with a simultaneous push: no bypass; data becomes visible the next cycle.
- Pointers are log2(`FIFO_DEPTH`)+1 bits. They wrap naturally. Full = MSBs differ and LSBs equal.
- `clear_status_i` has priority over a same-cycle set; the flag reads 0 afterwards.

## Timing
- Reset values:
  - `iis_data_o`=0, `iis_valid_o`=0.
  - `rx_valid_o`=0, `rx_data_o`=0.
  - `tx_ready_o`=1.
  - Sticky flags and counters = 0.
  - Both FIFOs empty.
- Reset asserted mid-operation flushes both FIFOs immediately (asynchronous). In-flight samples are lost.
- Tick detected combinationally in cycle N:
  - RX write occurs at the end of N; `rx_valid_o` is high in N+1.
  - `iis_data_o` updates and `iis_valid_o` is high in N+1 only.
- TX push in cycle N can be popped by a tick in cycle N+1 or later.
- Throughput: at most one RX and one TX sample per tick. The filter may drain RX one per cycle.

## Configuration
- `STUDENT_BRIDGE_STATS_EN` defined: adds outputs `rx_drop_cnt_o` [7:0] and `tx_underrun_cnt_o` [7:0].
  - Each counter increments on every drop or underrun event.
  - Counters saturate at 255.
  - Counters are cleared by `clear_status_i` and by reset.
- Undefined: these ports and counters do not exist. Sticky flags remain.

## Structure
- `student_bridge_pkg`:
  - `sample_t` (logic [15:0]).
  - `SAMPLE_W`=16.
  - `CNT_W`=8.
- Sub-module `student_sync_fifo` (parameters: width, depth):
  - First-word-fall-through.
  - Ports: `push`, `pop`, `full`, `empty`, `wdata`, `rdata`.
  - Instantiated twice, once for RX and once for TX.
- Tick detector, TX output register and status logic live in the top module.

## Test plan
- Reset: hold `iis_valid_i` low, release reset. Then `rx_valid_o`=0, `tx_ready_o`=1, `iis_data_o`=0, flags 0.
- Level-to-event: hold `iis_valid_i` high 500 cycles with data 0x1234. Exactly one RX entry (0x1234) and exactly one one-cycle `iis_valid_o` pulse result.
- RX overflow: `rx_ready_i`=0, 9 ticks with `FIFO_DEPTH`=8. Then `rx_overflow_o`=1, 8 entries in order, 9th lost, drop count 1 with macro.
- TX pacing: push 0xAAAA and 0x5555, then 2 ticks. `iis_data_o` reads 0xAAAA then 0x5555, each held until the next tick.
- Underrun: empty TX FIFO, tick after last sample 0x5555. With `UNDERRUN_ZERO`=0, `iis_data_o` stays 0x5555; with 1, it reads 0x0000. `tx_underrun_o`=1 in both cases; `clear_status_i` clears it.
- Mid-operation reset: assert `rst_ni` with 3 entries queued in each FIFO. After release both FIFOs are empty and all outputs are at reset values.

Source files
------------

// File: rtl/student_bridge_pkg.sv
// rtl/student_bridge_pkg.sv - shared sample type and widths for the IIS sample bridge
package student_bridge_pkg;
    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 8;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/student_sync_fifo.sv
// rtl/student_sync_fifo.sv - first-word-fall-through synchronous FIFO with extra-MSB pointers
module student_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A push on a full FIFO is only taken when the same cycle frees a slot.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/student_iis_sample_bridge.sv
// rtl/student_iis_sample_bridge.sv - IIS handler <-> FIR sample bridge; STUDENT_BRIDGE_STATS_EN adds drop/underrun counters
module student_iis_sample_bridge
    import student_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter bit UNDERRUN_ZERO = 1'b0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  sample_t iis_data_i,
    input  logic    iis_valid_i,
    output sample_t iis_data_o,
    output logic    iis_valid_o,
    output sample_t rx_data_o,
    output logic    rx_valid_o,
    input  logic    rx_ready_i,
    input  sample_t tx_data_i,
    input  logic    tx_valid_i,
    output logic    tx_ready_o,
    input  logic    clear_status_i,
    output logic    rx_overflow_o,
    output logic    tx_underrun_o
`ifdef STUDENT_BRIDGE_STATS_EN
    ,
    output logic [CNT_W-1:0] rx_drop_cnt_o,
    output logic [CNT_W-1:0] tx_underrun_cnt_o
`endif
);
    logic    r_valid_prev;
    sample_t r_iis_data;
    logic    r_iis_valid;
    logic    r_rx_overflow;
    logic    r_tx_underrun;

    logic    w_tick;
    logic    w_rx_full;
    logic    w_rx_empty;
    logic    w_rx_pop;
    logic    w_rx_drop;
    logic    w_tx_full;
    logic    w_tx_empty;
    logic    w_tx_push;
    logic    w_tx_pop;
    logic    w_underrun;
    sample_t w_tx_head;

    // The handler holds valid high for a whole frame; only the rising edge is a sample event.
    assign w_tick     = iis_valid_i & ~r_valid_prev;
    assign w_rx_pop   = ~w_rx_empty & rx_ready_i;
    assign w_rx_drop  = w_tick & w_rx_full & ~w_rx_pop;
    assign w_tx_push  = tx_valid_i & ~w_tx_full;
    assign w_tx_pop   = w_tick & ~w_tx_empty;
    assign w_underrun = w_tick & w_tx_empty;

    student_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (w_tick & ~w_rx_drop),
        .pop    (w_rx_pop),
        .wdata  (iis_data_i),
        .rdata  (rx_data_o),
        .full   (w_rx_full),
        .empty  (w_rx_empty)
    );

    student_sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (w_tx_push),
        .pop    (w_tx_pop),
        .wdata  (tx_data_i),
        .rdata  (w_tx_head),
        .full   (w_tx_full),
        .empty  (w_tx_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_prev  <= 1'b0;
            r_iis_data    <= '0;
            r_iis_valid   <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_valid_prev <= iis_valid_i;
            r_iis_valid  <= w_tick;
            if (w_tx_pop)
                r_iis_data <= w_tx_head;
            else if (w_underrun && UNDERRUN_ZERO)
                r_iis_data <= '0;

            if (clear_status_i) begin
                r_rx_overflow <= 1'b0;
                r_tx_underrun <= 1'b0;
            end else begin
                if (w_rx_drop)  r_rx_overflow <= 1'b1;
                if (w_underrun) r_tx_underrun <= 1'b1;
            end
        end
    end

`ifdef STUDENT_BRIDGE_STATS_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_underrun_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else if (clear_status_i) begin
            r_drop_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_rx_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_underrun && r_underrun_cnt != '1)
                r_underrun_cnt <= r_underrun_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rx_drop_cnt_o     = r_drop_cnt;
    assign tx_underrun_cnt_o = r_underrun_cnt;
`endif

    assign iis_data_o    = r_iis_data;
    assign iis_valid_o   = r_iis_valid;
    assign rx_valid_o    = ~w_rx_empty;
    assign tx_ready_o    = ~w_tx_full;
    assign rx_overflow_o = r_rx_overflow;
    assign tx_underrun_o = r_tx_underrun;
endmodule

// File: tb/tb_student_iis_sample_bridge.sv
// tb/tb_student_iis_sample_bridge.sv - self-checking bench for student_iis_sample_bridge
module tb_student_iis_sample_bridge;
    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] iis_data_i = '0;
    logic        iis_valid_i = 1'b0;
    logic        rx_ready_i = 1'b0;
    logic [15:0] tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        clear_status_i = 1'b0;

    logic [15:0] iis_data_o, rx_data_o, z_iis_data_o, z_rx_data_o;
    logic        iis_valid_o, rx_valid_o, tx_ready_o, rx_overflow_o, tx_underrun_o;
    logic        z_iis_valid_o, z_rx_valid_o, z_tx_ready_o, z_rx_overflow_o, z_tx_underrun_o;
`ifdef STUDENT_BRIDGE_STATS_EN
    logic [7:0]  rx_drop_cnt_o, tx_underrun_cnt_o, z_rx_drop_cnt_o, z_tx_underrun_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    student_iis_sample_bridge #(.FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .iis_data_i(iis_data_i), .iis_valid_i(iis_valid_i),
        .iis_data_o(iis_data_o), .iis_valid_o(iis_valid_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .clear_status_i(clear_status_i),
        .rx_overflow_o(rx_overflow_o), .tx_underrun_o(tx_underrun_o)
`ifdef STUDENT_BRIDGE_STATS_EN
        , .rx_drop_cnt_o(rx_drop_cnt_o), .tx_underrun_cnt_o(tx_underrun_cnt_o)
`endif
    );

    student_iis_sample_bridge #(.FIFO_DEPTH(DEPTH), .UNDERRUN_ZERO(1'b1)) dut_z (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .iis_data_i(iis_data_i), .iis_valid_i(iis_valid_i),
        .iis_data_o(z_iis_data_o), .iis_valid_o(z_iis_valid_o),
        .rx_data_o(z_rx_data_o), .rx_valid_o(z_rx_valid_o), .rx_ready_i(rx_ready_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(z_tx_ready_o),
        .clear_status_i(clear_status_i),
        .rx_overflow_o(z_rx_overflow_o), .tx_underrun_o(z_tx_underrun_o)
`ifdef STUDENT_BRIDGE_STATS_EN
        , .rx_drop_cnt_o(z_rx_drop_cnt_o), .tx_underrun_cnt_o(z_tx_underrun_cnt_o)
`endif
    );

    // Reference model: sample queues plus the observable registers.
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    logic        m_prev;
    logic [15:0] m_data, m_data_z;
    logic        m_valid, m_ovf, m_und;
    int          m_drop_cnt, m_und_cnt;

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_prev = 0; m_data = '0; m_data_z = '0; m_valid = 0;
        m_ovf = 0; m_und = 0; m_drop_cnt = 0; m_und_cnt = 0;
    endtask

    task automatic model_step();
        bit tick, rxpop;
        int rxn, txn;
        tick  = iis_valid_i && !m_prev;
        rxn   = rx_q.size();
        txn   = tx_q.size();
        rxpop = (rxn > 0) && rx_ready_i;
        if (rxpop) void'(rx_q.pop_front());
        if (tick) begin
            if (rxn == DEPTH && !rxpop) begin
                m_ovf = 1;
                if (m_drop_cnt < 255) m_drop_cnt++;
            end else begin
                rx_q.push_back(iis_data_i);
            end
            if (txn > 0) begin
                m_data   = tx_q.pop_front();
                m_data_z = m_data;
            end else begin
                m_data_z = '0;
                m_und    = 1;
                if (m_und_cnt < 255) m_und_cnt++;
            end
        end
        m_valid = tick;
        if (tx_valid_i && txn < DEPTH) tx_q.push_back(tx_data_i);
        if (clear_status_i) begin
            m_ovf = 0; m_und = 0; m_drop_cnt = 0; m_und_cnt = 0;
        end
        m_prev = iis_valid_i;
    endtask

    task automatic cyc(input logic iv, input logic [15:0] id, input logic rr,
                       input logic tv, input logic [15:0] td, input logic clr);
        iis_valid_i = iv; iis_data_i = id; rx_ready_i = rr;
        tx_valid_i = tv; tx_data_i = td; clear_status_i = clr;
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;
        model_reset();
        #1;
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0h exp=0", rx_valid_o); end
        checks++; if (rx_data_o !== 16'h0) begin failures++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data_o); end
        checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%0h exp=1", tx_ready_o); end
        checks++; if (iis_data_o !== 16'h0) begin failures++; $display("FAIL reset_iis_data got=%0h exp=0", iis_data_o); end
        checks++; if (iis_valid_o !== 1'b0) begin failures++; $display("FAIL reset_iis_valid got=%0h exp=0", iis_valid_o); end
        checks++; if ({rx_overflow_o, tx_underrun_o} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%0b exp=00", {rx_overflow_o, tx_underrun_o}); end
`ifdef STUDENT_BRIDGE_STATS_EN
        checks++; if ({rx_drop_cnt_o, tx_underrun_cnt_o} !== 16'h0) begin failures++; $display("FAIL reset_counts got=%0h exp=0", {rx_drop_cnt_o, tx_underrun_cnt_o}); end
`endif
    endtask

    task automatic test_level_to_event();
        int pulses = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(1, 16'h1234, 0, 0, 16'h0, 0);
            if (iis_valid_o === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL level_pulses got=%0d exp=1", pulses); end
        checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 16'h1234) begin failures++; $display("FAIL level_rx_head got=%0b/%0h exp=1/1234", rx_valid_o, rx_data_o); end
        cyc(1, 16'h1234, 1, 0, 16'h0, 0);
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL level_single_entry got=%0b exp=0", rx_valid_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 1);
    endtask

    task automatic test_rx_overflow();
        for (int i = 0; i < 9; i++) begin
            cyc(1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0);
            cyc(0, 16'h0, 0, 0, 16'h0, 0);
        end
        checks++; if (rx_overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", rx_overflow_o); end
        checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL ovf_tx_ready got=%0b exp=1", tx_ready_o); end
`ifdef STUDENT_BRIDGE_STATS_EN
        checks++; if (rx_drop_cnt_o !== 8'd1) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=1", rx_drop_cnt_o); end
`endif
        for (int i = 0; i < 8; i++) begin
            checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL ovf_order[%0d] got=%0b/%0h exp=1/%0h", i, rx_valid_o, rx_data_o, 16'h0100 + 16'(i)); end
            cyc(0, 16'h0, 1, 0, 16'h0, 0);
        end
        checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_ninth_lost got=%0b exp=0", rx_valid_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 1);
        checks++; if (rx_overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", rx_overflow_o); end
    endtask

    task automatic test_tx_pacing_underrun();
        cyc(0, 16'h0, 1, 1, 16'hAAAA, 0);
        cyc(0, 16'h0, 1, 1, 16'h5555, 0);
        cyc(0, 16'h0, 1, 0, 16'h0, 0);
        cyc(1, 16'h0, 1, 0, 16'h0, 0);
        checks++; if (iis_valid_o !== 1'b1 || iis_data_o !== 16'hAAAA) begin failures++; $display("FAIL pace_first got=%0b/%0h exp=1/aaaa", iis_valid_o, iis_data_o); end
        for (int i = 0; i < 5; i++) cyc(1, 16'h0, 1, 0, 16'h0, 0);
        checks++; if (iis_valid_o !== 1'b0 || iis_data_o !== 16'hAAAA) begin failures++; $display("FAIL pace_hold got=%0b/%0h exp=0/aaaa", iis_valid_o, iis_data_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 0);
        cyc(1, 16'h0, 1, 0, 16'h0, 0);
        checks++; if (iis_valid_o !== 1'b1 || iis_data_o !== 16'h5555 || z_iis_data_o !== 16'h5555) begin failures++; $display("FAIL pace_second got=%0b/%0h/%0h exp=1/5555/5555", iis_valid_o, iis_data_o, z_iis_data_o); end
        checks++; if (tx_underrun_o !== 1'b0) begin failures++; $display("FAIL pace_no_underrun got=%0b exp=0", tx_underrun_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 0);
        cyc(1, 16'h0, 1, 0, 16'h0, 0);
        checks++; if (iis_valid_o !== 1'b1 || iis_data_o !== 16'h5555) begin failures++; $display("FAIL underrun_repeat got=%0b/%0h exp=1/5555", iis_valid_o, iis_data_o); end
        checks++; if (z_iis_valid_o !== 1'b1 || z_iis_data_o !== 16'h0000) begin failures++; $display("FAIL underrun_zero got=%0b/%0h exp=1/0", z_iis_valid_o, z_iis_data_o); end
        checks++; if (tx_underrun_o !== 1'b1 || z_tx_underrun_o !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%0b%0b exp=11", tx_underrun_o, z_tx_underrun_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 1);
        checks++; if (tx_underrun_o !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%0b exp=0", tx_underrun_o); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0700 + 16'(i), 0, 0, 16'h0, 0);
            cyc(0, 16'h0, 0, 0, 16'h0, 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 0, 1, 16'h0900 + 16'(i), 0);
        cyc(0, 16'h0, 0, 0, 16'h0, 0);
        checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 16'h0700) begin failures++; $display("FAIL midrst_prefill got=%0b/%0h exp=1/700", rx_valid_o, rx_data_o); end
        #3 rst_ni = 0;
        #1;
        checks++; if (rx_valid_o !== 1'b0 || rx_data_o !== 16'h0) begin failures++; $display("FAIL midrst_async_rx got=%0b/%0h exp=0/0", rx_valid_o, rx_data_o); end
        @(posedge clk_i);
        #1 rst_ni = 1;
        model_reset();
        cyc(0, 16'h0, 0, 0, 16'h0, 0);
        checks++; if (rx_valid_o !== 1'b0 || tx_ready_o !== 1'b1 || iis_data_o !== 16'h0 || iis_valid_o !== 1'b0 || rx_overflow_o !== 1'b0 || tx_underrun_o !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got=%0b%0b%0h%0b%0b%0b exp=0 1 0 0 0 0", rx_valid_o, tx_ready_o, iis_data_o, iis_valid_o, rx_overflow_o, tx_underrun_o); end
        cyc(1, 16'hBEEF, 0, 0, 16'h0, 0);
        checks++; if (iis_valid_o !== 1'b1 || tx_underrun_o !== 1'b1) begin failures++; $display("FAIL midrst_tx_empty got=%0b%0b exp=11", iis_valid_o, tx_underrun_o); end
        cyc(0, 16'h0, 1, 0, 16'h0, 1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 40) == 0));
            checks++;
            if (rx_valid_o !== (rx_q.size() > 0) || rx_data_o !== (rx_q.size() > 0 ? rx_q[0] : 16'h0) ||
                tx_ready_o !== (tx_q.size() < DEPTH) || iis_data_o !== m_data || iis_valid_o !== m_valid ||
                z_iis_data_o !== m_data_z || rx_overflow_o !== m_ovf || tx_underrun_o !== m_und) begin
                failures++;
                if (bad++ < 10)
                    $display("FAIL random[%0d] got rxv=%0b rxd=%0h txr=%0b d=%0h v=%0b dz=%0h ovf=%0b und=%0b exp rxv=%0b rxd=%0h txr=%0b d=%0h v=%0b dz=%0h ovf=%0b und=%0b",
                             n, rx_valid_o, rx_data_o, tx_ready_o, iis_data_o, iis_valid_o, z_iis_data_o, rx_overflow_o, tx_underrun_o,
                             rx_q.size() > 0, rx_q.size() > 0 ? rx_q[0] : 16'h0, tx_q.size() < DEPTH, m_data, m_valid, m_data_z, m_ovf, m_und);
            end
`ifdef STUDENT_BRIDGE_STATS_EN
            checks++;
            if (int'(rx_drop_cnt_o) != m_drop_cnt || int'(tx_underrun_cnt_o) != m_und_cnt) begin
                failures++;
                $display("FAIL random_counts[%0d] got=%0d/%0d exp=%0d/%0d", n, rx_drop_cnt_o, tx_underrun_cnt_o, m_drop_cnt, m_und_cnt);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_level_to_event();
        test_rx_overflow();
        test_tx_pacing_underrun();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
